// File: rtl/m4to1_mux_pkg.sv
// m4to1_mux_pkg
//   Shared constants for the registered 4:1 multiplexer.
//   - SEL_A..SEL_D : select codes for the four data inputs.
//   - IMPL_*       : names of the two core styles, used by the IMPL parameter.
package m4to1_mux_pkg;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    localparam string IMPL_BEHAVIOR = "BEHAVIOR";
    localparam string IMPL_RTL      = "RTL";

endpackage : m4to1_mux_pkg

// File: rtl/m4to1_mux_core.sv
// m4to1_mux_core
//   Purely combinational 4:1 selection, applied bitwise across WIDTH.
//   IMPL chooses the style:
//     "BEHAVIOR" - case statement on the select code
//     "RTL"      - sum-of-products gate equation per bit
//   Any other IMPL value stops elaboration.
// Ports
//   Sin     in  [1:0]        select code (00=A, 01=B, 10=C, 11=D)
//   A..D    in  [WIDTH-1:0]  data inputs
//   sel_val out [WIDTH-1:0]  selected data
module m4to1_mux_core
    import m4to1_mux_pkg::*;
#(
    parameter int    WIDTH = 1,
    parameter string IMPL  = IMPL_BEHAVIOR
) (
    input  logic [1:0]       Sin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] sel_val
);

    if (IMPL == IMPL_BEHAVIOR) begin : g_behavior

        // An X/Z select matches no item and falls to the default, so an
        // unknown select shows up as all-X instead of quietly picking A.
        always_comb begin
            sel_val = 'x;
            case (Sin)
                SEL_A:   sel_val = A;
                SEL_B:   sel_val = B;
                SEL_C:   sel_val = C;
                SEL_D:   sel_val = D;
                default: sel_val = 'x;
            endcase
        end

    end else if (IMPL == IMPL_RTL) begin : g_rtl

        logic s1;
        logic s0;

        assign s1 = Sin[1];
        assign s0 = Sin[0];

        // One product term per input; exactly one term is live for any
        // known select code.
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign sel_val[i] = (~s1 & ~s0 & A[i])
                              | (~s1 &  s0 & B[i])
                              | ( s1 & ~s0 & C[i])
                              | ( s1 &  s0 & D[i]);
        end

    end else begin : g_bad_impl

        $error("m4to1_mux_core: IMPL must be \"BEHAVIOR\" or \"RTL\"");

    end

endmodule : m4to1_mux_core

// File: rtl/m4to1_mux.sv
// m4to1_mux
//   Registered 4:1 multiplexer. The selected input is captured on every
//   rising clock edge (one cycle of latency, no enable, no handshake).
//   A synchronous active-high reset clears the output and takes priority
//   over the data path.
// Ports (positional order is fixed for existing instances)
//   out  out [WIDTH-1:0]  registered mux result
//   Sin  in  [1:0]        select code (00=A, 01=B, 10=C, 11=D)
//   A..D in  [WIDTH-1:0]  data inputs
//   clk  in               rising-edge clock
//   rst  in               synchronous active-high reset
module m4to1_mux
    import m4to1_mux_pkg::*;
#(
    parameter int    WIDTH = 1,
    parameter string IMPL  = IMPL_BEHAVIOR
) (
    output logic [WIDTH-1:0] out,
    input  logic [1:0]       Sin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic             clk,
    input  logic             rst
);

    logic [WIDTH-1:0] sel_val;

    m4to1_mux_core #(
        .WIDTH (WIDTH),
        .IMPL  (IMPL)
    ) u_core (
        .Sin     (Sin),
        .A       (A),
        .B       (B),
        .C       (C),
        .D       (D),
        .sel_val (sel_val)
    );

    // Reset drops whatever was selected this cycle; the first edge with
    // rst low loads the current selection.
    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= sel_val;
        end
    end

endmodule : m4to1_mux

// File: tb/tb_m4to1_mux.sv
// tb_m4to1_mux
//   Three instances share one stimulus: WIDTH=1 BEHAVIOR, WIDTH=1 RTL and
//   WIDTH=8 BEHAVIOR. The 1-bit instances see bit 0 of the 8-bit data.
module tb_m4to1_mux;
    import m4to1_mux_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sin = 2'b00;
    logic [7:0] a = '0, b = '0, c = '0, d = '0;

    always #5 clk = ~clk;

    logic       out_beh;
    logic       out_rtl;
    logic [7:0] out_w8;

    m4to1_mux #(.WIDTH(1), .IMPL("BEHAVIOR")) dut_beh (
        .out(out_beh), .Sin(sin), .A(a[0]), .B(b[0]), .C(c[0]), .D(d[0]),
        .clk(clk), .rst(rst)
    );

    m4to1_mux #(.WIDTH(1), .IMPL("RTL")) dut_rtl (
        .out(out_rtl), .Sin(sin), .A(a[0]), .B(b[0]), .C(c[0]), .D(d[0]),
        .clk(clk), .rst(rst)
    );

    m4to1_mux #(.WIDTH(8), .IMPL("BEHAVIOR")) dut_w8 (
        .out(out_w8), .Sin(sin), .A(a), .B(b), .C(c), .D(d),
        .clk(clk), .rst(rst)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- reference model ----------------
    // Selection as an array lookup; a register edge either clears or
    // captures that lookup.
    function automatic logic [7:0] pick(input logic [1:0] s,
                                        input logic [7:0] wa, input logic [7:0] wb,
                                        input logic [7:0] wc, input logic [7:0] wd);
        logic [7:0] tbl [4];
        tbl[0] = wa; tbl[1] = wb; tbl[2] = wc; tbl[3] = wd;
        return tbl[s];
    endfunction

    logic [7:0] exp_q [$];

    always @(posedge clk) begin
        exp_q.push_back(rst ? 8'h00 : pick(sin, a, b, c, d));
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("model_beh", {7'b0, out_beh}, {7'b0, e[0]});
            check("model_rtl", {7'b0, out_rtl}, {7'b0, e[0]});
            check("model_w8", out_w8, e);
            check("beh_vs_rtl", {7'b0, out_rtl}, {7'b0, out_beh});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [1:0] s, input logic [7:0] wa, input logic [7:0] wb,
                         input logic [7:0] wc, input logic [7:0] wd);
        sin = s; a = wa; b = wb; c = wc; d = wd;
    endtask

    // Advance past one rising edge; outputs are settled on return.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic bit_want, input logic [7:0] w8_want);
        check({name, "_beh"}, {7'b0, out_beh}, {7'b0, bit_want});
        check({name, "_rtl"}, {7'b0, out_rtl}, {7'b0, bit_want});
        check({name, "_w8"}, out_w8, w8_want);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset held two edges with every data input high.
        rst = 1'b1;
        drive(SEL_A, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        step(); lit("reset_1", 1'b0, 8'h00);
        step(); lit("reset_2", 1'b0, 8'h00);

        // Release onto D.
        rst = 1'b0;
        drive(SEL_D, 8'h00, 8'h00, 8'h00, 8'hFF);
        step(); lit("release_d", 1'b1, 8'hFF);

        // C selected, then the other three toggle every cycle.
        drive(SEL_C, 8'h00, 8'h00, 8'hFF, 8'h00);
        step(); lit("sel_c", 1'b1, 8'hFF);
        for (int i = 0; i < 6; i++) begin
            a = ~a; b = ~b; d = ~d;
            step(); lit("c_hold", 1'b1, 8'hFF);
        end

        // B selected with D also high, then B falls.
        drive(SEL_B, 8'h00, 8'hFF, 8'h00, 8'hFF);
        step(); lit("sel_b", 1'b1, 8'hFF);
        b = 8'h00;
        step(); lit("b_low", 1'b0, 8'h00);

        // Select and data change together.
        drive(SEL_C, 8'h00, 8'h00, 8'h5A, 8'h00);
        step(); lit("sel_and_data", 1'b0, 8'h5A);

        // Mid-stream reset on A.
        drive(SEL_A, 8'hFF, 8'h00, 8'h00, 8'h00);
        step(); lit("sel_a", 1'b1, 8'hFF);
        rst = 1'b1;
        step(); lit("mid_reset", 1'b0, 8'h00);
        rst = 1'b0;
        step(); lit("after_reset", 1'b1, 8'hFF);

        // Exhaustive 1-bit sweep; each data bit is spread across the byte.
        for (int i = 0; i < 64; i++) begin
            logic [5:0] v;
            v = 6'(i);
            drive(v[5:4], {8{v[3]}}, {8{v[2]}}, {8{v[1]}}, {8{v[0]}});
            step();
        end

        // Width-8 select sweep.
        drive(SEL_A, 8'h11, 8'h22, 8'h44, 8'h88);
        step(); lit("w8_a", 1'b1, 8'h11);
        sin = SEL_B;
        step(); lit("w8_b", 1'b0, 8'h22);
        sin = SEL_C;
        step(); lit("w8_c", 1'b0, 8'h44);
        sin = SEL_D;
        step(); lit("w8_d", 1'b0, 8'h88);

        // Let the last queued expectation be checked.
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_m4to1_mux
